adc_capture_ctrl: RTL and testbench

//  Capture sequencer directly downstream of the trigger unit, in the ADC clock domain.
//  On a rising edge of capture_go_i it waits a programmed offset, streams a fixed number of
//  ADC samples into the sample FIFO, then raises capture_done_o back to the trigger unit.
//  It flags FIFO overflow and reports progress to the register block.

---
 rtl/adc_capture_ctrl_pkg.sv | 24 ++
 rtl/capture_down_counter.sv | 28 ++
 rtl/adc_capture_ctrl.sv | 178 +++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_ctrl_pkg.sv
// Shared types and default widths for the ADC capture sequencer.
// Optional decimation is enabled with the CAPTURE_DOWNSAMPLE_EN macro.
package adc_capture_ctrl_pkg;

  localparam int unsigned ADC_W_DEF        = 10;
  localparam int unsigned SAMPLE_CNT_W_DEF = 16;
  localparam int unsigned OFFSET_W_DEF     = 32;
`ifdef CAPTURE_DOWNSAMPLE_EN
  localparam int unsigned DOWNSAMPLE_W     = 16;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } capture_state_t;

  // A capture is in flight while waiting out the offset or streaming samples.
  function automatic logic is_busy(input capture_state_t s);
    return (s == ST_DELAY) || (s == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/capture_down_counter.sv
// Loadable saturating down-counter with a zero terminal flag.
module capture_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement; the count sticks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: after a go edge, waits offset_i cycles then streams max_samples_i
// ADC samples into the sample FIFO. Decimation is added under CAPTURE_DOWNSAMPLE_EN.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int unsigned ADC_W        = ADC_W_DEF,
  parameter int unsigned SAMPLE_CNT_W = SAMPLE_CNT_W_DEF,
  parameter int unsigned OFFSET_W     = OFFSET_W_DEF
) (
  input  logic                    adc_clk,
  input  logic                    reset_n,
  input  logic                    capture_go_i,
  input  logic [ADC_W-1:0]        adc_data_i,
  input  logic [OFFSET_W-1:0]     offset_i,
  input  logic [SAMPLE_CNT_W-1:0] max_samples_i,
`ifdef CAPTURE_DOWNSAMPLE_EN
  input  logic [15:0]             downsample_i,
`endif
  input  logic                    fifo_full_i,
  output logic                    fifo_wr_en_o,
  output logic [ADC_W-1:0]        fifo_data_o,
  output logic                    capture_active_o,
  output logic                    capture_done_o,
  output logic                    overflow_o,
  output logic [SAMPLE_CNT_W-1:0] sample_count_o
);

  capture_state_t          state_q, state_d;
  logic                    go_q;
  logic                    go_edge_c;
  logic [SAMPLE_CNT_W-1:0] max_q;
  logic [SAMPLE_CNT_W-1:0] cnt_inc_c;
  logic                    latch_c;
  logic                    write_c;
  logic                    drop_c;
  logic                    dly_load_c;
  logic                    dly_en_c;
  logic                    dly_zero_c;
  logic                    keep_c;

  assign go_edge_c = capture_go_i & ~go_q;
  assign cnt_inc_c = (&sample_count_o) ? sample_count_o : sample_count_o + SAMPLE_CNT_W'(1);

  // Delay counter is loaded with offset-1 so it hits zero on the edge that moves to CAPTURE.
  capture_down_counter #(.W(OFFSET_W)) u_delay_cnt (
    .clk      (adc_clk),
    .reset_n  (reset_n),
    .load     (dly_load_c),
    .load_val (offset_i - OFFSET_W'(1)),
    .en       (dly_en_c),
    .zero_c   (dly_zero_c)
  );

`ifdef CAPTURE_DOWNSAMPLE_EN
  logic [DOWNSAMPLE_W-1:0] ds_q;
  logic                    dec_load_c;
  logic                    dec_en_c;
  logic                    dec_zero_c;

  // Skip counter: zero means keep; reloaded with the ratio after every kept sample.
  assign dec_load_c = latch_c | write_c;
  assign dec_en_c   = (state_q == ST_CAPTURE) & capture_go_i & ~dec_zero_c;

  capture_down_counter #(.W(DOWNSAMPLE_W)) u_decim_cnt (
    .clk      (adc_clk),
    .reset_n  (reset_n),
    .load     (dec_load_c),
    .load_val (latch_c ? '0 : ds_q),
    .en       (dec_en_c),
    .zero_c   (dec_zero_c)
  );

  assign keep_c = dec_zero_c;

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      ds_q <= '0;
    end else if (latch_c) begin
      ds_q <= downsample_i;
    end
  end
`else
  assign keep_c = 1'b1;
`endif

  // Next-state and per-edge strobes.
  always_comb begin
    state_d    = state_q;
    latch_c    = 1'b0;
    write_c    = 1'b0;
    drop_c     = 1'b0;
    dly_load_c = 1'b0;
    dly_en_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_edge_c) begin
          latch_c    = 1'b1;
          dly_load_c = 1'b1;
          if (max_samples_i == '0) begin
            state_d = ST_DONE;
          end else if (offset_i == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        if (!capture_go_i) begin
          state_d = ST_IDLE;
        end else if (dly_zero_c) begin
          state_d = ST_CAPTURE;
        end else begin
          dly_en_c = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (!capture_go_i) begin
          state_d = ST_IDLE;
        end else if (keep_c) begin
          if (fifo_full_i) begin
            drop_c  = 1'b1;
            state_d = ST_DONE;
          end else begin
            write_c = 1'b1;
            if (cnt_inc_c >= max_q) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (!capture_go_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // go_q resets high so a go level already present at reset release is not an edge.
  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      go_q             <= 1'b1;
      max_q            <= '0;
      fifo_wr_en_o     <= 1'b0;
      fifo_data_o      <= '0;
      capture_active_o <= 1'b0;
      capture_done_o   <= 1'b0;
      overflow_o       <= 1'b0;
      sample_count_o   <= '0;
    end else begin
      state_q          <= state_d;
      go_q             <= capture_go_i;
      fifo_wr_en_o     <= write_c;
      capture_active_o <= is_busy(state_d);
      capture_done_o   <= (state_q == ST_DONE) & capture_go_i;
      if (latch_c) begin
        max_q <= max_samples_i;
      end
      if (write_c) begin
        fifo_data_o <= adc_data_i;
      end
      if (latch_c) begin
        sample_count_o <= '0;
      end else if (write_c) begin
        sample_count_o <= cnt_inc_c;
      end
      if (latch_c) begin
        overflow_o <= 1'b0;
      end else if (drop_c) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: ramped ADC data, FIFO write scoreboard, immediate assertions.
module tb_adc_capture_ctrl;

  localparam int unsigned ADC_W        = 10;
  localparam int unsigned SAMPLE_CNT_W = 16;
  localparam int unsigned OFFSET_W     = 32;

  logic                    adc_clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    capture_go_i = 1'b0;
  logic [ADC_W-1:0]        adc_data_i;
  logic [OFFSET_W-1:0]     offset_i = '0;
  logic [SAMPLE_CNT_W-1:0] max_samples_i = '0;
`ifdef CAPTURE_DOWNSAMPLE_EN
  logic [15:0]             downsample_i = '0;
`endif
  logic                    fifo_full_i = 1'b0;
  logic                    fifo_wr_en_o;
  logic [ADC_W-1:0]        fifo_data_o;
  logic                    capture_active_o;
  logic                    capture_done_o;
  logic                    overflow_o;
  logic [SAMPLE_CNT_W-1:0] sample_count_o;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int active_cycles = 0;
  int n0;
  logic [ADC_W-1:0] wr_q[$];

  adc_capture_ctrl #(
    .ADC_W(ADC_W), .SAMPLE_CNT_W(SAMPLE_CNT_W), .OFFSET_W(OFFSET_W)
  ) dut (
    .adc_clk          (adc_clk),
    .reset_n          (reset_n),
    .capture_go_i     (capture_go_i),
    .adc_data_i       (adc_data_i),
    .offset_i         (offset_i),
    .max_samples_i    (max_samples_i),
`ifdef CAPTURE_DOWNSAMPLE_EN
    .downsample_i     (downsample_i),
`endif
    .fifo_full_i      (fifo_full_i),
    .fifo_wr_en_o     (fifo_wr_en_o),
    .fifo_data_o      (fifo_data_o),
    .capture_active_o (capture_active_o),
    .capture_done_o   (capture_done_o),
    .overflow_o       (overflow_o),
    .sample_count_o   (sample_count_o)
  );

  always #5 adc_clk = ~adc_clk;

  // Ramp: data seen at an edge equals the cycle number read by the stimulus just before it.
  always @(posedge adc_clk) cyc <= cyc + 1;
  assign adc_data_i = ADC_W'(cyc);

  always @(negedge adc_clk) begin
    if (fifo_wr_en_o) wr_q.push_back(fifo_data_o);
    if (capture_active_o) active_cycles++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge adc_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_writes(input string tag, input int base, input int stride, input int n);
    chk($sformatf("%s.nwr", tag), 32'(wr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++)
      chk($sformatf("%s.wr%0d", tag, i), 32'(wr_q[i]), 32'(ADC_W'(base + i * stride)));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".wr_en"},  32'(fifo_wr_en_o),     32'(0));
    chk({tag, ".active"}, 32'(capture_active_o), 32'(0));
    chk({tag, ".done"},   32'(capture_done_o),   32'(0));
  endtask

  task automatic start(input int off, input int mx);
    offset_i      = OFFSET_W'(off);
    max_samples_i = SAMPLE_CNT_W'(mx);
    wr_q.delete();
    active_cycles = 0;
    n0            = cyc;
    capture_go_i  = 1'b1;
  endtask

  initial begin
    // Reset with go already high: all outputs zero, and release starts nothing.
    capture_go_i = 1'b1;
    step(3);
    chk_idle("rst");
    chk("rst.data",  32'(fifo_data_o),    32'(0));
    chk("rst.ovf",   32'(overflow_o),     32'(0));
    chk("rst.count", 32'(sample_count_o), 32'(0));
    reset_n = 1'b1;
    wr_q.delete();
    step(6);
    chk_idle("gohigh");
    chk("gohigh.nwr", 32'(wr_q.size()), 32'(0));
    capture_go_i = 1'b0;
    step(2);

    // 1: offset 0, max 4.
    start(0, 4);
    step(1);
    chk("t1.active", 32'(capture_active_o), 32'(1));
    chk("t1.wr_en0", 32'(fifo_wr_en_o),     32'(0));
    step(4);
    chk("t1.count", 32'(sample_count_o), 32'(4));
    chk("t1.done_early", 32'(capture_done_o), 32'(0));
    step(1);
    chk("t1.done", 32'(capture_done_o), 32'(1));
    chk("t1.wr_en_end", 32'(fifo_wr_en_o), 32'(0));
    chk_writes("t1", n0 + 1, 1, 4);
    capture_go_i = 1'b0;
    step(1);
    chk_idle("t1.rel");
    step(2);

    // 2: offset 10, max 3.
    start(10, 3);
    step(15);
    chk("t2.active_cycles", 32'(active_cycles), 32'(13));
    chk("t2.done",  32'(capture_done_o), 32'(1));
    chk("t2.count", 32'(sample_count_o), 32'(3));
    chk_writes("t2", n0 + 11, 1, 3);
    capture_go_i = 1'b0;
    step(2);

    // 3: max 0 goes straight to DONE without writing.
    start(5, 0);
    step(1);
    chk("t3.done0",  32'(capture_done_o),   32'(0));
    chk("t3.active", 32'(capture_active_o), 32'(0));
    step(1);
    chk("t3.done1", 32'(capture_done_o), 32'(1));
    chk("t3.nwr", 32'(wr_q.size()), 32'(0));
    capture_go_i = 1'b0;
    step(1);
    chk("t3.rel", 32'(capture_done_o), 32'(0));
    step(1);

    // 4: FIFO full before the third sample.
    start(0, 8);
    step(3);
    fifo_full_i = 1'b1;
    step(1);
    chk("t4.ovf",   32'(overflow_o),     32'(1));
    chk("t4.wr_en", 32'(fifo_wr_en_o),   32'(0));
    chk("t4.count", 32'(sample_count_o), 32'(2));
    step(1);
    chk("t4.done", 32'(capture_done_o), 32'(1));
    chk_writes("t4", n0 + 1, 1, 2);
    fifo_full_i  = 1'b0;
    capture_go_i = 1'b0;
    step(2);
    chk("t4.sticky", 32'(overflow_o), 32'(1));
    start(0, 1);
    step(1);
    chk("t4.ovf_clr",   32'(overflow_o),     32'(0));
    chk("t4.count_clr", 32'(sample_count_o), 32'(0));
    step(2);
    capture_go_i = 1'b0;
    step(2);

    // 5a: reset mid-CAPTURE, go stays high through release.
    start(0, 8);
    step(3);
    reset_n = 1'b0;
    step(1);
    chk_idle("t5a");
    chk("t5a.count", 32'(sample_count_o), 32'(0));
    chk("t5a.data",  32'(fifo_data_o),    32'(0));
    reset_n = 1'b1;
    step(5);
    chk_idle("t5a.after");
    chk("t5a.nwr", 32'(wr_q.size()), 32'(2));
    capture_go_i = 1'b0;
    step(2);

    // 5b: go falls during DELAY.
    start(6, 2);
    step(3);
    chk("t5b.active", 32'(capture_active_o), 32'(1));
    capture_go_i = 1'b0;
    step(1);
    chk("t5b.abort", 32'(capture_active_o), 32'(0));
    step(10);
    chk_idle("t5b.after");
    chk("t5b.nwr", 32'(wr_q.size()), 32'(0));

`ifdef CAPTURE_DOWNSAMPLE_EN
    // 6: keep one sample in three.
    downsample_i = 16'd2;
    start(0, 3);
    step(9);
    chk("t6.done", 32'(capture_done_o), 32'(1));
    chk_writes("t6", n0 + 1, 3, 3);
    capture_go_i = 1'b0;
    step(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
